// File: rtl/transmissor_paridade_serial.sv
// Serial frame transmitter: start, 8 data bits LSB first, parity, stop.
// Parity comes from the 8-bit generator, inverted for even-parity builds.

module gerador_paridade (
    input  logic [7:0] dados,
    output logic       paridade
);
    assign paridade = ~^dados;
endmodule

module transmissor_paridade_serial #(
    parameter int unsigned DIV            = 4,
    parameter int unsigned PARIDADE_IMPAR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dados,
    input  logic       valido,
    output logic       pronto,
    output logic       tx,
    output logic       ocupado,
    output logic       fim
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_ULT = CW'(DIV - 1);
    localparam logic [CW-1:0] DIV_PEN = (DIV > 1) ? CW'(DIV - 2) : '0;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } estado_t;

    estado_t       r_estado;
    logic [CW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_tx;
    logic          r_pronto;
    logic          r_ocupado;
    logic          r_fim;

    logic w_paridade;
    logic w_par_sel;
    logic w_fim_bit;

    gerador_paridade u_gerador (
        .dados    (dados),
        .paridade (w_paridade)
    );

    assign w_par_sel = (PARIDADE_IMPAR != 0) ? w_paridade : ~w_paridade;
    assign w_fim_bit = (r_div == DIV_ULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= OCIOSO;
            r_div     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_pronto  <= 1'b1;
            r_ocupado <= 1'b0;
            r_fim     <= 1'b0;
        end else begin
            r_fim <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    r_tx      <= 1'b1;
                    r_pronto  <= 1'b1;
                    r_ocupado <= 1'b0;
                    r_div     <= '0;
                    r_bit     <= '0;
                    if (valido && r_pronto) begin
                        r_shift   <= dados;
                        r_par     <= w_par_sel;
                        r_estado  <= INICIO;
                        r_tx      <= 1'b0;
                        r_pronto  <= 1'b0;
                        r_ocupado <= 1'b1;
                    end
                end
                INICIO: begin
                    if (w_fim_bit) begin
                        r_div    <= '0;
                        r_estado <= DADOS;
                        r_tx     <= r_shift[0];
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                DADOS: begin
                    if (w_fim_bit) begin
                        r_div   <= '0;
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_estado <= PARIDADE;
                            r_tx     <= r_par;
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                PARIDADE: begin
                    if (w_fim_bit) begin
                        r_div    <= '0;
                        r_estado <= PARADA;
                        r_tx     <= 1'b1;
                        // one-cycle stop bit: its only cycle is also the last
                        r_fim    <= (DIV == 1);
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                PARADA: begin
                    if (w_fim_bit) begin
                        r_div     <= '0;
                        r_estado  <= OCIOSO;
                        r_tx      <= 1'b1;
                        r_pronto  <= 1'b1;
                        r_ocupado <= 1'b0;
                    end else begin
                        r_div <= r_div + 1'b1;
                        r_fim <= (r_div == DIV_PEN);
                    end
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_div     <= '0;
                    r_bit     <= '0;
                    r_tx      <= 1'b1;
                    r_pronto  <= 1'b1;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign pronto  = r_pronto;
    assign tx      = r_tx;
    assign ocupado = r_ocupado;
    assign fim     = r_fim;

endmodule
